// File: rtl/viterbi_pkg.sv
// Shared constants and encoder helpers for the hard-decision Viterbi decoder.
// Latency: n/a (constants and constant functions only).
// Backpressure: n/a.
// Contents: default code parameters (constraint length, depth, metric width,
// generator polynomials), the trellis state count and the parity /
// expected-symbol functions used to build the branch metrics.
package viterbi_pkg;

  localparam int VIT_K  = 4;
  localparam int VIT_D  = 24;
  localparam int VIT_WM = 6;
  localparam int VIT_G0 = 'o17;
  localparam int VIT_G1 = 'o13;

  // Number of trellis states for constraint length k.
  function automatic int num_states(input int k);
    return 1 << (k - 1);
  endfunction

  localparam int VIT_NS = num_states(VIT_K);

  function automatic logic parity32(input logic [31:0] v);
    return ^v;
  endfunction

  // Symbol the encoder emits when input bit b enters with state s:
  // r = {b, s}, bit1 = parity(r & g0), bit0 = parity(r & g1).
  function automatic logic [1:0] expected_sym(input int k, input int b,
                                              input int s, input int g0,
                                              input int g1);
    logic [31:0] r;
    r = (32'(b) << (k - 1)) | 32'(s);
    return {parity32(r & 32'(g0)), parity32(r & 32'(g1))};
  endfunction

endpackage

// File: rtl/viterbi_acs.sv
// Add-compare-select for one trellis state (purely combinational).
// Latency: 0 cycles; result is registered by the parent.
// Backpressure: none; evaluated every cycle, parent decides whether to commit.
// Ports: pm_even/pm_odd, surv_even/surv_odd - metric and survivor of the two
// predecessors (LSB 0 / LSB 1); rx_sym - received hard symbol;
// pm_new - saturated winning metric; surv_new - extended D-bit survivor.
module viterbi_acs
  import viterbi_pkg::*;
#(
  parameter int K     = VIT_K,
  parameter int D     = VIT_D,
  parameter int Wm    = VIT_WM,
  parameter int G0    = VIT_G0,
  parameter int G1    = VIT_G1,
  parameter int STATE = 0
) (
  input  logic [Wm-1:0] pm_even,
  input  logic [Wm-1:0] pm_odd,
  input  logic [D-2:0]  surv_even,
  input  logic [D-2:0]  surv_odd,
  input  logic [1:0]    rx_sym,
  output logic [Wm-1:0] pm_new,
  output logic [D-1:0]  surv_new
);

  localparam int NS = num_states(K);
  // The newest input bit is the MSB of the destination state.
  localparam int B  = (STATE >> (K - 2)) & 1;
  // Both predecessors share the destination's low bits shifted up by one.
  localparam int P0 = (STATE << 1) & (NS - 1);
  localparam int P1 = P0 + 1;

  localparam logic [1:0]  EXP0    = expected_sym(K, B, P0, G0, G1);
  localparam logic [1:0]  EXP1    = expected_sym(K, B, P1, G0, G1);
  localparam logic [Wm:0] MAX_EXT = {1'b0, {Wm{1'b1}}};
  localparam logic [Wm-1:0] MAX_M = '1;

  logic [1:0]  diff0, diff1;
  logic [1:0]  bm0, bm1;
  logic [Wm:0] sum0, sum1, win;
  logic        take_odd;

  always_comb begin
    diff0 = rx_sym ^ EXP0;
    diff1 = rx_sym ^ EXP1;
    bm0   = {1'b0, diff0[1]} + {1'b0, diff0[0]};
    bm1   = {1'b0, diff1[1]} + {1'b0, diff1[0]};
    // One extra bit so the sums never wrap before saturation.
    sum0  = {1'b0, pm_even} + {{(Wm - 1){1'b0}}, bm0};
    sum1  = {1'b0, pm_odd}  + {{(Wm - 1){1'b0}}, bm1};
    // Strict compare: a tie keeps the even (LSB 0) predecessor.
    take_odd = (sum1 < sum0);
    win      = take_odd ? sum1 : sum0;
    pm_new   = (win > MAX_EXT) ? MAX_M : win[Wm-1:0];
    surv_new = {(take_odd ? surv_odd : surv_even), 1'(B)};
  end

endmodule

// File: rtl/viterbi_core.sv
// Hard-decision register-exchange Viterbi decoder, one symbol per cycle.
// Latency: bit for symbol n is strobed the cycle after symbol n+D-1 is accepted.
// Backpressure: rx_sym_ready is high every cycle out of reset; output cannot stall.
// Ports: clk, rst (async active-low); rx_sym_valid/rx_sym_ready/rx_sym - input
// symbol handshake (bit1 = G0 output, bit0 = G1 output); force_state0 - drive
// the trellis toward state 0 during the tail; dec_bit_valid/dec_bit - output.
module viterbi_core
  import viterbi_pkg::*;
#(
  parameter int K      = VIT_K,
  parameter int D      = VIT_D,
  parameter int Wm     = VIT_WM,
  parameter int G0_OCT = VIT_G0,
  parameter int G1_OCT = VIT_G1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_sym_valid,
  output logic       rx_sym_ready,
  input  logic [1:0] rx_sym,
  input  logic       force_state0,
  output logic       dec_bit_valid,
  output logic       dec_bit
);

  localparam int NS = num_states(K);
  localparam int SW = K - 1;
  localparam int CW = $clog2(D + 1);
  localparam logic [Wm-1:0] MAX_M = '1;

  // Only D-1 survivor bits are stored: the MSB of a freshly extended survivor
  // is consumed by the output mux in the same cycle and would be shifted out
  // on the next accept anyway.
  logic [NS-1:0][Wm-1:0] metric_q, metric_d;
  logic [NS-1:0][D-2:0]  surv_q, surv_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  ready_q, ready_d;
  logic                  dec_vld_q, dec_vld_d;
  logic                  dec_bit_q, dec_bit_d;

  logic [NS-1:0][Wm-1:0] acs_metric;
  logic [NS-1:0][D-1:0]  acs_surv;
  logic [NS-1:0][Wm-1:0] forced_metric;
  logic [Wm-1:0]         min_m;
  logic [SW-1:0]         min_idx;
  logic [SW-1:0]         out_state;
  logic                  accept;

  for (genvar s = 0; s < NS; s++) begin : g_acs
    localparam int P0 = (s << 1) & (NS - 1);
    viterbi_acs #(
      .K    (K),
      .D    (D),
      .Wm   (Wm),
      .G0   (G0_OCT),
      .G1   (G1_OCT),
      .STATE(s)
    ) u_acs (
      .pm_even  (metric_q[P0]),
      .pm_odd   (metric_q[P0 + 1]),
      .surv_even(surv_q[P0]),
      .surv_odd (surv_q[P0 + 1]),
      .rx_sym   (rx_sym),
      .pm_new   (acs_metric[s]),
      .surv_new (acs_surv[s])
    );
  end

  always_comb begin
    accept = rx_sym_valid & ready_q;

    // Forcing is applied to the saturated metrics before normalisation, so
    // state 0 becomes the minimum and everything else sits far above it.
    for (int i = 0; i < NS; i++) begin
      forced_metric[i] = (force_state0 && (i != 0)) ? MAX_M : acs_metric[i];
    end

    // Lowest index wins among equal minima.
    min_m   = forced_metric[0];
    min_idx = '0;
    for (int i = 1; i < NS; i++) begin
      if (forced_metric[i] < min_m) begin
        min_m   = forced_metric[i];
        min_idx = SW'(i);
      end
    end
    out_state = force_state0 ? '0 : min_idx;

    metric_d  = metric_q;
    surv_d    = surv_q;
    cnt_d     = cnt_q;
    ready_d   = 1'b1;
    dec_vld_d = 1'b0;
    dec_bit_d = dec_bit_q;

    if (accept) begin
      for (int i = 0; i < NS; i++) begin
        metric_d[i] = forced_metric[i] - min_m;
        surv_d[i]   = acs_surv[i][D-2:0];
      end
      if (cnt_q != CW'(D)) begin
        cnt_d = cnt_q + CW'(1);
      end
      // This accept is the D-th (or later) since reset.
      if (cnt_q >= CW'(D - 1)) begin
        dec_vld_d = 1'b1;
        dec_bit_d = acs_surv[out_state][D-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NS; i++) begin
        metric_q[i] <= (i == 0) ? '0 : MAX_M;
      end
      surv_q    <= '0;
      cnt_q     <= '0;
      ready_q   <= 1'b0;
      dec_vld_q <= 1'b0;
      dec_bit_q <= 1'b0;
    end else begin
      metric_q  <= metric_d;
      surv_q    <= surv_d;
      cnt_q     <= cnt_d;
      ready_q   <= ready_d;
      dec_vld_q <= dec_vld_d;
      dec_bit_q <= dec_bit_d;
    end
  end

  assign rx_sym_ready  = ready_q;
  assign dec_bit_valid = dec_vld_q;
  assign dec_bit       = dec_bit_q;

endmodule

// File: tb/tb_viterbi_core.sv
// Scoreboarded bench for viterbi_core with a path-history reference decoder.
// Latency: expected bits are queued at issue and popped when the DUT strobes.
// Backpressure: stimulus inserts random idle cycles; the DUT never stalls.
module tb_viterbi_core;

  localparam int K    = 4;
  localparam int D    = 24;
  localparam int WM   = 6;
  localparam int G0   = 'o17;
  localparam int G1   = 'o13;
  localparam int NS   = 1 << (K - 1);
  localparam int MAXM = (1 << WM) - 1;
  localparam int MAXL = 1024;

  typedef logic [1:0] sym_q_t[$];
  typedef bit         bit_q_t[$];

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx_sym_valid = 1'b0;
  logic       rx_sym_ready;
  logic [1:0] rx_sym = 2'b00;
  logic       force_state0 = 1'b0;
  logic       dec_bit_valid;
  logic       dec_bit;

  always #5 clk = ~clk;

  viterbi_core #(
    .K(K), .D(D), .Wm(WM), .G0_OCT(G0), .G1_OCT(G1)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .rx_sym_valid (rx_sym_valid),
    .rx_sym_ready (rx_sym_ready),
    .rx_sym       (rx_sym),
    .force_state0 (force_state0),
    .dec_bit_valid(dec_bit_valid),
    .dec_bit      (dec_bit)
  );

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;
  bit drv_due = 1'b0;
  bit due_s = 1'b0;
  bit exp_q[$];
  bit got_q[$];

  // Reference decoder state: metrics and complete decision paths per state.
  int pm[NS];
  bit hist[NS][MAXL];
  int hlen;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: actual %0d required %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic int parity(input int v);
    int p = 0;
    for (int i = 0; i < 32; i++) p = p ^ ((v >> i) & 1);
    return p;
  endfunction

  // Encoder output for input b entering state s.
  function automatic logic [1:0] enc(input int s, input int b);
    int r;
    r = (b << (K - 1)) | s;
    return {1'(parity(r & G0)), 1'(parity(r & G1))};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NS; i++) pm[i] = (i == 0) ? 0 : MAXM;
    hlen = 0;
  endtask

  task automatic model_step(input logic [1:0] sym, input bit f, output bit due);
    int cand[NS];
    int from[NS];
    int bin[NS];
    int mn, ch, ns, m;
    logic [1:0] e;
    bit nh[NS][MAXL];
    for (int i = 0; i < NS; i++) cand[i] = 1 << 30;
    // Walk every transition; ascending predecessor order keeps LSB-0 on ties.
    for (int s = 0; s < NS; s++) begin
      for (int b = 0; b < 2; b++) begin
        ns = ((b << (K - 1)) | s) >> 1;
        e  = enc(s, b);
        m  = pm[s] + int'(sym[1] ^ e[1]) + int'(sym[0] ^ e[0]);
        if (m < cand[ns]) begin
          cand[ns] = m;
          from[ns] = s;
          bin[ns]  = b;
        end
      end
    end
    mn = 1 << 30;
    ch = 0;
    for (int i = 0; i < NS; i++) begin
      if (cand[i] > MAXM) cand[i] = MAXM;
      if (f && i != 0) cand[i] = MAXM;
      if (cand[i] < mn) begin
        mn = cand[i];
        ch = i;
      end
    end
    if (f) ch = 0;
    for (int i = 0; i < NS; i++) begin
      pm[i] = cand[i] - mn;
      for (int j = 0; j < hlen; j++) nh[i][j] = hist[from[i]][j];
      nh[i][hlen] = bin[i][0];
    end
    hist = nh;
    if (hlen < MAXL - 1) hlen++;
    due = (hlen >= D);
    if (due) exp_q.push_back(hist[ch][hlen - D]);
  endtask

  task automatic drive(input bit v, input logic [1:0] s, input bit f);
    bit due;
    @(posedge clk);
    #1;
    rx_sym_valid = v;
    rx_sym       = s;
    force_state0 = f;
    due = 1'b0;
    if (v) model_step(s, f, due);
    drv_due = due;
  endtask

  always @(posedge clk) due_s = drv_due;

  always @(negedge clk) begin
    if (chk_en) begin
      check("strobe", dec_bit_valid, due_s);
      if (dec_bit_valid && due_s) begin
        check("model_queue_nonempty", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          check("dec_bit", dec_bit, exp_q.pop_front());
          got_q.push_back(dec_bit);
        end
      end
    end
  end

  task automatic reset_release();
    repeat (3) begin
      @(negedge clk);
      check("rst_ready", rx_sym_ready, 0);
      check("rst_valid", dec_bit_valid, 0);
      check("rst_bit", dec_bit, 0);
    end
    rst = 1'b1;
    model_reset();
    exp_q.delete();
    got_q.delete();
    @(posedge clk);
    #1;
    check("ready_after_reset", rx_sym_ready, 1);
    chk_en = 1'b1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    chk_en       = 1'b0;
    rx_sym_valid = 1'b0;
    drv_due      = 1'b0;
    rst          = 1'b0;
    reset_release();
  endtask

  task automatic drain();
    repeat (2) drive(1'b0, 2'($urandom), 1'($urandom));
    check("drained", exp_q.size(), 0);
  endtask

  task automatic run_syms(input sym_q_t syms, input bit f, input int stall_pct);
    foreach (syms[i]) begin
      while ($urandom_range(0, 99) < stall_pct) drive(1'b0, 2'($urandom), 1'($urandom));
      drive(1'b1, syms[i], f);
    end
  endtask

  task automatic encode_bits(input bit_q_t bits, output sym_q_t syms);
    int s = 0;
    syms.delete();
    foreach (bits[i]) begin
      syms.push_back(enc(s, int'(bits[i])));
      s = ((int'(bits[i]) << (K - 1)) | s) >> 1;
    end
  endtask

  task automatic check_src(input string name, input bit_q_t src, input int nsym);
    check({name, "_count"}, got_q.size(), nsym - (D - 1));
    foreach (src[i]) begin
      if (i < got_q.size()) check(name, got_q[i], src[i]);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    sym_q_t syms, err_syms;
    bit_q_t src;

    reset_release();

    // All-zero stream: 7 strobes, all 0.
    syms.delete();
    src.delete();
    repeat (30) begin syms.push_back(2'b00); src.push_back(1'b0); end
    run_syms(syms, 1'b0, 0);
    drain();
    check_src("zeros", src, 30);
    do_reset();

    // Impulse: 11,10,11,11 then 30 zeros decodes to 1 then 0s.
    syms = '{2'b11, 2'b10, 2'b11, 2'b11};
    src.delete();
    src.push_back(1'b1);
    repeat (30) syms.push_back(2'b00);
    repeat (33) src.push_back(1'b0);
    run_syms(syms, 1'b0, 0);
    drain();
    check_src("impulse", src, 34);
    do_reset();

    // Error correction: 200 random bits plus flush, one flip every 12 symbols.
    src.delete();
    repeat (200) src.push_back(1'($urandom));
    repeat (26) src.push_back(1'b0);
    encode_bits(src, err_syms);
    foreach (err_syms[i]) begin
      if (i % 12 == 11) begin
        if ($urandom_range(0, 1) == 1) err_syms[i] ^= 2'b01;
        else err_syms[i] ^= 2'b10;
      end
    end
    run_syms(err_syms, 1'b0, 0);
    drain();
    check_src("ecc", src, err_syms.size());
    do_reset();

    // Same stream with random valid gaps.
    run_syms(err_syms, 1'b0, 30);
    drain();
    check_src("stall", src, err_syms.size());
    do_reset();

    // Tail forcing: message + 3 zero tail bits, then 24 forced 00 symbols.
    src.delete();
    repeat (40) src.push_back(1'($urandom));
    repeat (3) src.push_back(1'b0);
    encode_bits(src, syms);
    run_syms(syms, 1'b0, 0);
    syms.delete();
    repeat (24) begin syms.push_back(2'b00); src.push_back(1'b0); end
    run_syms(syms, 1'b1, 0);
    drain();
    check_src("tail", src, 67);
    do_reset();

    // Random symbols, random forcing and gaps, with a mid-stream reset.
    for (int i = 0; i < 300; i++) begin
      if (i == 150) do_reset();
      while ($urandom_range(0, 99) < 20) drive(1'b0, 2'($urandom), 1'($urandom));
      drive(1'b1, 2'($urandom), ($urandom_range(0, 99) < 10));
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/viterbi_core.md
VITERBI_CORE -- requirements
Module: viterbi_core

Interface
REQ-001 SHALL have parameter K, default 4, meaning the constraint length; the trellis has 2^(K-1) states.
REQ-002 SHALL have parameter D, default 24, meaning the survivor/decision depth in symbols.
REQ-003 SHALL have parameter Wm, default 6, meaning the path-metric width in bits.
REQ-004 SHALL have parameter G0_OCT, default octal 17, meaning the generator polynomial for the first code bit.
REQ-005 SHALL have parameter G1_OCT, default octal 13, meaning the generator polynomial for the second code bit.
REQ-006 SHALL have port clk  in  1  meaning the single clock; all state changes on the rising edge.
REQ-007 SHALL have port rst  in  1  meaning the reset, which is asynchronous and active-low.
REQ-008 SHALL have port rx_sym_valid  in  1  meaning a received symbol is offered.
REQ-009 SHALL have port rx_sym_ready  out  1  meaning the core can accept a symbol.
REQ-010 SHALL have port rx_sym  in  2  meaning the hard-decision symbol; bit1 is the G0 output, bit0 is the G1 output.
REQ-011 SHALL have port force_state0  in  1  meaning tail/termination forcing toward state 0.
REQ-012 SHALL have port dec_bit_valid  out  1  meaning a one-cycle strobe qualifying dec_bit.
REQ-013 SHALL have port dec_bit  out  1  meaning the decoded information bit.

Function
REQ-014 SHALL accept a symbol on a cycle where rx_sym_valid and rx_sym_ready are both high; rx_sym_ready SHALL be high on every cycle out of reset, giving one symbol per cycle.
REQ-015 SHALL use this encoder model: state s = last K-1 input bits; register r = {b, s} with b as the MSB; out0 = parity(r AND G0); out1 = parity(r AND G1); next state = r[K-1:1].
REQ-016 SHALL use the Hamming distance (0..2) between rx_sym and the expected {out0,out1} as the branch metric.
REQ-017 SHALL, for each accepted symbol, add-compare-select all states in that same cycle; on a metric tie the predecessor with LSB 0 wins.
REQ-018 SHALL saturate each new metric at 2^Wm-1 and then subtract the minimum new metric from all of them, so the minimum stored metric is always 0.
REQ-019 SHALL keep a D-bit register-exchange survivor per state: new survivor = {predecessor survivor[D-2:0], b}.
REQ-020 SHALL choose the output state as the lowest-index state with minimum new metric, or state 0 if force_state0 is high on the accept cycle.
REQ-021 SHALL, when force_state0 is high on an accept, set every new metric except state 0 to 2^Wm-1.
REQ-022 SHALL register dec_bit as survivor bit D-1 of the chosen state and pulse dec_bit_valid for one cycle, in the cycle after an accept, once at least D symbols have been accepted since reset; the accept counter saturates at D.
REQ-023 SHALL therefore present the decoded bit for symbol n in the cycle after symbol n+D-1 is accepted.
REQ-024 SHALL leave all state unchanged and hold dec_bit_valid low on cycles without an accept.

Reset
REQ-025 SHALL, while rst is low: hold rx_sym_ready=0, dec_bit_valid=0 and dec_bit=0; set the state-0 metric to 0 and all other metrics to 2^Wm-1; clear all survivors and the counter.
REQ-026 SHALL discard all trellis history when reset is asserted mid-stream, so the next valid output again needs D new accepts.

Structure
REQ-027 SHALL put K, the state count, the generator constants, and the parity/expected-symbol functions in the shared package viterbi_pkg.
REQ-028 SHALL use one natural sub-module, viterbi_acs, the per-state add-compare-select, instantiated 2^(K-1) times.

Verification
REQ-029 SHALL check reset: rst low, then high -> ready=0 and outputs 0 during reset; ready=1 on the first cycle after.
REQ-030 SHALL check all-zero input: 30 symbols 00 -> first dec_bit_valid follows the 24th accept, then 7 strobes, all dec_bit=0.
REQ-031 SHALL check the impulse: symbols 11,10,11,11 then 00x30 -> decoded stream 1 followed by 0s.
REQ-032 SHALL check error correction: 200 random bits encoded with one bit flipped every 12 symbols -> decoded stream equals the source bits.
REQ-033 SHALL check stalls: the REQ-032 stream with rx_sym_valid randomly deasserted -> identical decoded sequence, one strobe per accept after the 24th.
REQ-034 SHALL check tail forcing: a message plus 3 zero tail bits, then 24 symbols 00 with force_state0=1 -> every message bit emitted correctly.
